// File: rtl/user_logic_stream_shell.sv
// Multi-channel stream endpoint. It provides a decoded register bank, per-channel
// loopback FIFOs, beat counters, done flags and a masked completion interrupt.
module user_logic_stream_shell #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 64,
  parameter int FIFO_DEPTH  = 16,
  parameter int NUM_SCRATCH = 4
) (
  input  logic                     i_user_clk,
  input  logic                     i_rst,
  input  logic [31:0]              i_user_data,
  input  logic [19:0]              i_user_addr,
  input  logic                     i_user_wr_req,
  input  logic                     i_user_rd_req,
  output logic [31:0]              o_user_data,
  output logic                     o_user_rd_ack,
  input  logic [NUM_CH-1:0]        i_pcie_str_data_valid,
  output logic [NUM_CH-1:0]        o_pcie_str_ack,
  input  logic [NUM_CH*DATA_W-1:0] i_pcie_str_data,
  output logic [NUM_CH-1:0]        o_pcie_str_data_valid,
  input  logic [NUM_CH-1:0]        i_pcie_str_ack,
  output logic [NUM_CH*DATA_W-1:0] o_pcie_str_data,
  output logic                     o_intr_req,
  input  logic                     i_intr_ack
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_P = FIFO_DEPTH[AW:0];

  typedef logic [AW:0] ptr_t;

  logic [NUM_CH-1:0] en, mask, done, done_d;
  logic [31:0]       target  [NUM_CH];
  logic [31:0]       count   [NUM_CH];
  logic [31:0]       scratch [NUM_SCRATCH];
  logic              pending;
  logic [31:0]       rd_data;
  logic              rd_ack;

  ptr_t              wptr [NUM_CH];
  ptr_t              rptr [NUM_CH];
  logic [DATA_W-1:0] mem  [NUM_CH][FIFO_DEPTH];

  logic [NUM_CH-1:0] empty, full, push, pop, flush, done_set;
  logic [7:0]        idx;
  logic              wr_ctrl, wr_status, wr_mask, soft_clr;
  logic              qual_rise, qual_set;
  logic [31:0]       rd_mux;
  logic              unused_addr_bits;

  assign idx       = i_user_addr[9:2];
  assign wr_ctrl   = i_user_wr_req && (idx == 8'd0);
  assign wr_status = i_user_wr_req && (idx == 8'd1);
  assign wr_mask   = i_user_wr_req && (idx == 8'd2);
  assign soft_clr  = wr_ctrl && i_user_data[31];
  assign unused_addr_bits = ^{i_user_addr[19:10], i_user_addr[1:0]};

  always_comb begin
    empty                 = '0;
    full                  = '0;
    push                  = '0;
    pop                   = '0;
    flush                 = '0;
    done_set              = '0;
    o_pcie_str_ack        = '1;
    o_pcie_str_data_valid = '0;
    o_pcie_str_data       = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      empty[c]    = (wptr[c] == rptr[c]);
      full[c]     = ((wptr[c] - rptr[c]) == DEPTH_P);
      push[c]     = en[c] && i_pcie_str_data_valid[c] && !full[c];
      pop[c]      = en[c] && !empty[c] && i_pcie_str_ack[c];
      flush[c]    = soft_clr || (wr_ctrl && !i_user_data[c]);
      done_set[c] = pop[c] && (target[c] != '0) && ((count[c] + 32'd1) == target[c]);
      o_pcie_str_ack[c]        = en[c] ? !full[c] : 1'b1;
      o_pcie_str_data_valid[c] = en[c] && !empty[c];
      if (en[c] && !empty[c])
        o_pcie_str_data[c*DATA_W +: DATA_W] = mem[c][rptr[c][AW-1:0]];
    end
  end

  // An ack that lands on a qualifying done edge must not lose that interrupt.
  assign qual_rise = |(done & ~done_d & mask);
  assign qual_set  = |(done_set & ~done & mask);

  always_comb begin
    rd_mux = '0;
    case (idx)
      8'd0: rd_mux[NUM_CH-1:0] = en;
      8'd1: begin
        rd_mux[NUM_CH-1:0]  = done;
        rd_mux[8 +: NUM_CH] = empty;
      end
      8'd2: rd_mux[NUM_CH-1:0] = mask;
      default: ;
    endcase
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (idx == 8'(4 + c)) rd_mux = target[c];
      if (idx == 8'(8 + c)) rd_mux = count[c];
    end
    for (int unsigned k = 0; k < NUM_SCRATCH; k++)
      if (idx == 8'(16 + k)) rd_mux = scratch[k];
  end

  always_ff @(posedge i_user_clk) begin
    if (i_rst) begin
      en      <= '0;
      mask    <= '0;
      done    <= '0;
      done_d  <= '0;
      pending <= 1'b0;
      rd_data <= '0;
      rd_ack  <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        target[c] <= '0;
        count[c]  <= '0;
        wptr[c]   <= '0;
        rptr[c]   <= '0;
      end
      for (int unsigned k = 0; k < NUM_SCRATCH; k++)
        scratch[k] <= '0;
    end else begin
      rd_ack <= i_user_rd_req;
      if (i_user_rd_req) rd_data <= rd_mux;

      // A soft-clear write leaves the channel enables untouched.
      if (wr_ctrl && !i_user_data[31]) en <= i_user_data[NUM_CH-1:0];
      if (wr_mask) mask <= i_user_data[NUM_CH-1:0];

      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (flush[c]) begin
          wptr[c] <= '0;
          rptr[c] <= '0;
        end else begin
          if (push[c]) wptr[c] <= wptr[c] + 1'b1;
          if (pop[c])  rptr[c] <= rptr[c] + 1'b1;
        end
        if (soft_clr)    count[c] <= '0;
        else if (pop[c]) count[c] <= count[c] + 32'd1;
        if (soft_clr)                           done[c] <= 1'b0;
        else if (done_set[c])                   done[c] <= 1'b1;
        else if (wr_status && i_user_data[c])   done[c] <= 1'b0;
        if (i_user_wr_req && idx == 8'(4 + c))  target[c] <= i_user_data;
      end
      for (int unsigned k = 0; k < NUM_SCRATCH; k++)
        if (i_user_wr_req && idx == 8'(16 + k)) scratch[k] <= i_user_data;

      done_d <= done;
      if (soft_clr)
        pending <= 1'b0;
      else
        pending <= qual_rise || (pending && !(i_intr_ack && !qual_set));
    end
  end

  always_ff @(posedge i_user_clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++)
      if (push[c]) mem[c][wptr[c][AW-1:0]] <= i_pcie_str_data[c*DATA_W +: DATA_W];
  end

  assign o_user_data   = rd_data;
  assign o_user_rd_ack = rd_ack;
  assign o_intr_req    = pending;

endmodule

// File: tb/tb_user_logic_stream_shell.sv
// Bench for user_logic_stream_shell. A queue-based model predicts every output on
// every cycle, and directed literal checks pin the key scenarios.
module tb_user_logic_stream_shell;

  localparam int NC    = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int NS    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      wdata;
  logic [19:0]      addr;
  logic             wr_req, rd_req;
  logic [31:0]      rdata;
  logic             rd_ack;
  logic [NC-1:0]    in_valid, in_ack, out_valid, host_ack;
  logic [NC*DW-1:0] in_data, out_data;
  logic             intr_req, intr_ack;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  user_logic_stream_shell #(
    .NUM_CH(NC), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .NUM_SCRATCH(NS)
  ) dut (
    .i_user_clk(clk), .i_rst(rst),
    .i_user_data(wdata), .i_user_addr(addr),
    .i_user_wr_req(wr_req), .i_user_rd_req(rd_req),
    .o_user_data(rdata), .o_user_rd_ack(rd_ack),
    .i_pcie_str_data_valid(in_valid), .o_pcie_str_ack(in_ack),
    .i_pcie_str_data(in_data),
    .o_pcie_str_data_valid(out_valid), .i_pcie_str_ack(host_ack),
    .o_pcie_str_data(out_data),
    .o_intr_req(intr_req), .i_intr_ack(intr_ack)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] md_q [NC][$];
  logic [NC-1:0] md_en, md_mask, md_done, md_fresh;
  logic [31:0]   md_target [NC];
  logic [31:0]   md_count  [NC];
  logic [31:0]   md_scratch[NS];
  logic          md_pending, md_rd_ack;
  logic [31:0]   md_rd_data;

  function automatic logic [31:0] md_read(input int i);
    logic [31:0] r;
    r = '0;
    if (i == 0) r[NC-1:0] = md_en;
    else if (i == 1) begin
      r[NC-1:0] = md_done;
      for (int c = 0; c < NC; c++) r[8+c] = (md_q[c].size() == 0);
    end
    else if (i == 2) r[NC-1:0] = md_mask;
    else if (i >= 4 && i < 4 + NC) r = md_target[i-4];
    else if (i >= 8 && i < 8 + NC) r = md_count[i-8];
    else if (i >= 16 && i < 16 + NS) r = md_scratch[i-16];
    return r;
  endfunction

  always @(posedge clk) begin
    logic [NC-1:0] in_x, out_x, rising, pre_done;
    int widx;
    if (rst) begin
      md_en = '0; md_mask = '0; md_done = '0; md_fresh = '0;
      md_pending = 1'b0; md_rd_ack = 1'b0; md_rd_data = '0;
      for (int c = 0; c < NC; c++) begin
        md_q[c].delete(); md_target[c] = '0; md_count[c] = '0;
      end
      for (int k = 0; k < NS; k++) md_scratch[k] = '0;
    end else begin
      widx = int'(addr[9:2]);
      md_rd_ack = rd_req;
      if (rd_req) md_rd_data = md_read(widx);
      for (int c = 0; c < NC; c++) begin
        in_x[c]  = md_en[c] && in_valid[c] && (md_q[c].size() < DEPTH);
        out_x[c] = md_en[c] && (md_q[c].size() != 0) && host_ack[c];
      end
      pre_done = md_done;
      rising = '0;
      if (wr_req && widx == 1) md_done = md_done & ~wdata[NC-1:0];
      for (int c = 0; c < NC; c++) begin
        if (out_x[c]) begin
          void'(md_q[c].pop_front());
          md_count[c] = md_count[c] + 1;
          if (md_target[c] != 0 && md_count[c] == md_target[c]) begin
            if (!pre_done[c]) rising[c] = 1'b1;
            md_done[c] = 1'b1;
          end
        end
        if (in_x[c]) md_q[c].push_back(in_data[c*DW +: DW]);
      end
      if ((md_fresh & md_mask) != 0) md_pending = 1'b1;
      else if (intr_ack && (rising & md_mask) == 0) md_pending = 1'b0;
      md_fresh = rising;
      if (wr_req && widx == 0) begin
        if (wdata[31]) begin
          for (int c = 0; c < NC; c++) begin md_q[c].delete(); md_count[c] = '0; end
          md_done = '0; md_pending = 1'b0; md_fresh = '0;
        end else begin
          md_en = wdata[NC-1:0];
          for (int c = 0; c < NC; c++) if (!wdata[c]) md_q[c].delete();
        end
      end
      if (wr_req && widx == 2) md_mask = wdata[NC-1:0];
      for (int c = 0; c < NC; c++) if (wr_req && widx == 4 + c) md_target[c] = wdata;
      for (int k = 0; k < NS; k++) if (wr_req && widx == 16 + k) md_scratch[k] = wdata;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NC; c++) begin
        chk($sformatf("in_ack%0d", c), 64'(in_ack[c]),
            64'(!md_en[c] || md_q[c].size() < DEPTH));
        chk($sformatf("out_valid%0d", c), 64'(out_valid[c]),
            64'(md_en[c] && md_q[c].size() != 0));
        if (md_en[c] && md_q[c].size() != 0)
          chk($sformatf("out_data%0d", c), out_data[c*DW +: DW], md_q[c][0]);
      end
      chk("intr_req", 64'(intr_req), 64'(md_pending));
      chk("rd_ack", 64'(rd_ack), 64'(md_rd_ack));
      chk("rd_data", 64'(rdata), 64'(md_rd_data));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [19:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
  endtask

  task automatic rd(input logic [19:0] a, output logic [31:0] d);
    addr = a; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    d = rdata;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0]   d;
    logic          a1;
    logic [NC-1:0] a4;
    int            acc;
    int            seq [NC];

    rst = 1'b1; wdata = '0; addr = '0; wr_req = 1'b0; rd_req = 1'b0;
    in_valid = '0; in_data = '0; host_ack = '0; intr_ack = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset values
    chk("rst_in_ack", 64'(in_ack), 64'hF);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", out_data[63:0] | out_data[255:192], 64'h0);
    chk("rst_intr", 64'(intr_req), 64'h0);
    chk("rst_rdata", 64'(rdata), 64'h0);
    rd(20'h00, d); chk("rst_control", 64'(d), 64'h0); chk("rd_ack_pulse", 64'(rd_ack), 64'h1);
    rd(20'h04, d); chk("rst_status", 64'(d), 64'h0000_0F00);
    rd(20'h10, d); chk("rst_target0", 64'(d), 64'h0);

    // Channel 0 loopback, target 8, interrupt
    wr(20'h10, 32'd8);
    wr(20'h08, 32'h1);
    wr(20'h00, 32'h1);
    host_ack = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      in_valid[0] = 1'b1; in_data[63:0] = 64'(i);
      tick();
      if (i == 0) begin
        chk("ch0_first_valid", 64'(out_valid[0]), 64'h1);
        chk("ch0_first_data", out_data[63:0], 64'h0);
      end
    end
    in_valid = '0;
    tick(); chk("ch0_intr_early", 64'(intr_req), 64'h0);
    tick(); chk("ch0_intr_set", 64'(intr_req), 64'h1);
    rd(20'h20, d); chk("ch0_count", 64'(d), 64'd8);
    rd(20'h04, d); chk("ch0_status", 64'(d), 64'h0000_0F01);
    intr_ack = 1'b1; tick(); intr_ack = 1'b0;
    chk("ch0_intr_ack", 64'(intr_req), 64'h0);
    wr(20'h04, 32'h1);
    rd(20'h04, d); chk("ch0_w1c", 64'(d), 64'h0000_0F00);

    // Channel 1 fill to full, then drain
    wr(20'h00, 32'h3);
    host_ack = 4'b0001;
    acc = 0;
    for (int n = 0; n < 20; n++) begin
      in_valid[1] = 1'b1; in_data[64 +: 64] = 64'h100 + 64'(acc);
      a1 = in_ack[1];
      tick();
      if (a1) acc++;
    end
    chk("ch1_accepted_full", 64'(acc), 64'd16);
    chk("ch1_ack_full", 64'(in_ack[1]), 64'h0);
    host_ack = 4'b0011;
    tick();
    chk("ch1_ack_return", 64'(in_ack[1]), 64'h1);
    for (int n = 0; n < 100 && acc < 20; n++) begin
      in_data[64 +: 64] = 64'h100 + 64'(acc);
      a1 = in_ack[1];
      tick();
      if (a1) acc++;
    end
    chk("ch1_accepted_total", 64'(acc), 64'd20);
    in_valid = '0;
    repeat (20) tick();
    rd(20'h24, d); chk("ch1_count", 64'(d), 64'd20);

    // All channels, random backpressure
    wr(20'h00, 32'hF);
    for (int c = 0; c < NC; c++) seq[c] = 0;
    for (int n = 0; n < 200; n++) begin
      in_valid = 4'($urandom);
      host_ack = 4'($urandom);
      for (int c = 0; c < NC; c++)
        in_data[c*DW +: DW] = {8'(c + 1), 56'(seq[c])};
      a4 = in_ack & in_valid;
      tick();
      for (int c = 0; c < NC; c++) if (a4[c]) seq[c]++;
    end
    in_valid = '0; host_ack = 4'hF;
    repeat (40) tick();
    for (int c = 0; c < NC; c++) begin
      rd(20'h20 + 20'(4 * c), d);
      chk($sformatf("mix_count%0d", c), 64'(d), 64'(md_count[c]));
    end

    // W1C of done0 coinciding with a done1 rise and an interrupt ack
    wr(20'h00, 32'h8000_000F);
    wr(20'h10, 32'd1);
    wr(20'h14, 32'd1);
    wr(20'h08, 32'h3);
    host_ack = 4'b1101;
    in_valid = 4'b0011; in_data[63:0] = 64'hA0; in_data[127:64] = 64'hA1;
    tick();
    in_valid = '0;
    repeat (3) tick();
    chk("w1c_intr_pre", 64'(intr_req), 64'h1);
    rd(20'h04, d); chk("w1c_status_pre", 64'(d), 64'h0000_0D01);
    addr = 20'h04; wdata = 32'h1; wr_req = 1'b1; intr_ack = 1'b1; host_ack = 4'hF;
    tick();
    wr_req = 1'b0; intr_ack = 1'b0;
    chk("w1c_intr_hold0", 64'(intr_req), 64'h1);
    tick();
    chk("w1c_intr_hold1", 64'(intr_req), 64'h1);
    rd(20'h04, d); chk("w1c_status_post", 64'(d), 64'h0000_0F02);
    intr_ack = 1'b1; tick(); intr_ack = 1'b0;
    chk("w1c_intr_clear", 64'(intr_req), 64'h0);

    // Soft clear with data in FIFO2
    for (int i = 0; i < 3; i++) begin
      in_valid = 4'b0100; in_data[128 +: 64] = 64'hC0 + 64'(i);
      tick();
    end
    in_valid = '0;
    repeat (3) tick();
    host_ack = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      in_valid = 4'b0100; in_data[128 +: 64] = 64'hD0 + 64'(i);
      tick();
    end
    in_valid = '0;
    rd(20'h28, d); chk("sc_count_pre", 64'(d), 64'd3);
    rd(20'h04, d); chk("sc_status_pre", 64'(d), 64'h0000_0B02);
    wr(20'h40, 32'hDEAD_BEEF);
    wr(20'h4C, 32'h1234_5678);
    wr(20'h00, 32'h8000_0000);
    chk("sc_valid2", 64'(out_valid[2]), 64'h0);
    rd(20'h28, d); chk("sc_count", 64'(d), 64'h0);
    rd(20'h00, d); chk("sc_control", 64'(d), 64'hF);
    rd(20'h40, d); chk("sc_scratch0", 64'(d), 64'hDEAD_BEEF);
    rd(20'h4C, d); chk("sc_scratch3", 64'(d), 64'h1234_5678);
    rd(20'h04, d); chk("sc_status", 64'(d), 64'h0000_0F00);

    // Unmapped / out-of-range, and read-during-write
    wr(20'h50, 32'h5555_AAAA);
    rd(20'h50, d); chk("unmapped_scratch4", 64'(d), 64'h0);
    rd(20'h0C, d); chk("unmapped_0c", 64'(d), 64'h0);
    addr = 20'h40; wdata = 32'hCAFE_F00D; wr_req = 1'b1; rd_req = 1'b1;
    tick();
    wr_req = 1'b0; rd_req = 1'b0;
    chk("rw_same_old", 64'(rdata), 64'hDEAD_BEEF);
    rd(20'h40, d); chk("rw_same_new", 64'(d), 64'hCAFE_F00D);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/user_logic_stream_shell.md
# user_logic_stream_shell

Parametrised user-logic shell for the PCIe streaming wrapper: a NUM_CH-channel stream endpoint with a decoded register bank, per-channel loopback FIFOs, per-channel beat counters and a masked completion interrupt with request/ack handshake. It sits where the per-design user logic plugs into the PCIe register, stream and interrupt interfaces. It serves as the bring-up and regression target for multi-channel DMA, replacing single-register, fixed-channel test logic.

## Interface
- NUM_CH, 4, number of stream channels (1..4)
- DATA_W, 64, stream data width
- FIFO_DEPTH, 16, loopback FIFO depth per channel (power of 2, >=2)
- NUM_SCRATCH, 4, number of read/write scratch registers (1..8)

- i_user_clk  in  1  single clock, all logic rising-edge
- i_rst  in  1  reset, synchronous, active-high
- i_user_data  in  32  register write data
- i_user_addr  in  20  register byte address; index = i_user_addr[9:2]
- i_user_wr_req  in  1  one-cycle write strobe
- i_user_rd_req  in  1  one-cycle read strobe
- o_user_data  out  32  registered read data
- o_user_rd_ack  out  1  read acknowledge
- i_pcie_str_data_valid  in  NUM_CH  host->user valid, bit c = channel c
- o_pcie_str_ack  out  NUM_CH  host->user ready
- i_pcie_str_data  in  NUM_CH*DATA_W  host->user data, channel c at [c*DATA_W +: DATA_W]
- o_pcie_str_data_valid  out  NUM_CH  user->host valid
- i_pcie_str_ack  in  NUM_CH  user->host ready
- o_pcie_str_data  out  NUM_CH*DATA_W  user->host data
- o_intr_req  out  1  interrupt request level
- i_intr_ack  in  1  interrupt acknowledge pulse

## Operation
- Transfer on any stream = valid && ack at a rising edge.
- Register map (byte address):
  - 0x00 CONTROL rw: bit c = loopback enable ch c; bit 31 = soft clear (self-clearing, reads 0).
  - 0x04 STATUS: bits[NUM_CH-1:0] done flags (sticky, write-1-to-clear); bits[8+c] FIFO c empty (RO).
  - 0x08 INTR_MASK rw: bit c enables interrupt from done[c].
  - 0x10+4c BEAT_TARGET[c] rw; 0x20+4c BEAT_COUNT[c] RO; 0x40+4k SCRATCH[k] rw.
  - Registers for channels >= NUM_CH, unmapped and out-of-range scratch addresses: read 0, writes ignored.
- Channel disabled (CONTROL[c]=0): o_pcie_str_ack[c]=1, input discarded; o_pcie_str_data_valid[c]=0; FIFO c held empty.
- Channel enabled: input pushed into FIFO c; o_pcie_str_ack[c] = !full; o_pcie_str_data_valid[c] = !empty; o_pcie_str_data is FIFO head (first-word-fall-through). Push and pop in the same cycle are allowed at any non-full occupancy.
- Disabling a channel flushes its FIFO on the edge of the write; counts and done are kept.
- BEAT_COUNT[c]: increments on each output transfer of ch c; 32-bit, wraps 0xFFFFFFFF->0.
- done[c] sets on the output transfer that makes BEAT_COUNT[c] equal BEAT_TARGET[c]. It never sets when the target is 0. If a W1C to the same bit coincides with the setting beat, set wins.
- Interrupt: pending sets one cycle after done[c] rises with INTR_MASK[c]=1. o_intr_req = pending. i_intr_ack clears pending. If a new qualifying rise occurs in the ack cycle, pending stays 1.
- Soft clear: flushes all FIFOs and clears BEAT_COUNT, done and pending in one cycle. CONTROL enables, mask, targets and scratch are kept.
- Reset: all registers 0, FIFOs empty.

## Timing
- Reset values: o_user_data=0, o_user_rd_ack=0, o_pcie_str_data_valid=0, o_pcie_str_data=0, o_intr_req=0. o_pcie_str_ack resets to all 1s (all channels disabled).
- Read: o_user_rd_ack pulses the cycle after i_user_rd_req. o_user_data is valid in that cycle and holds until the next read.
- Write: takes effect on the strobe edge and is visible to a read issued the next cycle.
- Loopback latency: a beat accepted at edge N gives valid at N+1 when the FIFO was empty.
- Full: FIFO_DEPTH beats are accepted with no pops; ack falls after the last push. When a pop occurs in a full cycle, ack returns the next cycle.
- Done flag: visible in STATUS in the cycle after the setting beat. o_intr_req follows one cycle later.
- Simultaneous read and write to the same register: the read returns the pre-write value.

## Test plan
- Reset, then read 0x00/0x04/0x10 -> rd_ack one cycle after req; data 0, 0x00000F00 (all empty), 0; all str acks 1, all valids 0.
- Enable ch0, TARGET0=8, mask=1; stream 8 beats 0..7 with host ack held 1 -> output 0..7 in order, first valid 1 cycle after first accept; BEAT_COUNT0=8; done[0]; o_intr_req 2 cycles after beat 8; i_intr_ack clears it.
- Enable ch1, hold i_pcie_str_ack[1]=0, offer 20 beats -> exactly 16 accepted, ack[1]=0; release -> 16 beats drained in order, then 4 more accepted.
- All 4 channels enabled with distinct data and random backpressure -> no cross-channel mixing; per-channel counts exact.
- W1C done[0] in the same cycle as a new qualifying done[1] rise, with i_intr_ack -> done[0]=0, done[1]=1, o_intr_req stays 1.
- Soft clear with 5 beats in FIFO2 and BEAT_COUNT2=3 -> valid[2]=0 the next cycle, count 0, CONTROL and SCRATCH unchanged.
